// File: rtl/mem_xbar.sv
// Two-master (instr/data) to NSLV-slave memory crossbar: window decode, one-deep
// per-master request buffer, per-slave round-robin ownership FSM and response routing.
module mem_xbar #(
  parameter int NSLV = 3,
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter logic [NSLV*AW-1:0] SLV_BASE = {32'h8000_0000, 32'h1000_0000, 32'h0200_0000},
  parameter logic [NSLV*AW-1:0] SLV_TOP  = {32'h8001_0000, 32'h1000_1000, 32'h0201_0000},
  parameter logic [DW-1:0] ERR_RDATA = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   imemory_valid,
  input  logic                   imemory_instr,
  input  logic [AW-1:0]          imemory_addr,
  input  logic [DW-1:0]          imemory_wdata,
  input  logic [DW/8-1:0]        imemory_wstrb,
  output logic [DW-1:0]          imemory_rdata,
  output logic                   imemory_ready,
  output logic                   imemory_error,
  input  logic                   dmemory_valid,
  input  logic                   dmemory_instr,
  input  logic [AW-1:0]          dmemory_addr,
  input  logic [DW-1:0]          dmemory_wdata,
  input  logic [DW/8-1:0]        dmemory_wstrb,
  output logic [DW-1:0]          dmemory_rdata,
  output logic                   dmemory_ready,
  output logic                   dmemory_error,
  output logic [NSLV-1:0]        slv_valid,
  output logic [NSLV-1:0]        slv_instr,
  output logic [NSLV*AW-1:0]     slv_addr,
  output logic [NSLV*DW-1:0]     slv_wdata,
  output logic [NSLV*DW/8-1:0]   slv_wstrb,
  input  logic [NSLV*DW-1:0]     slv_rdata,
  input  logic [NSLV-1:0]        slv_ready
);
  localparam int BW = DW / 8;
  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} state_t;

  // Handshake: a master valid is a one-cycle pulse, accepted when the master has
  // nothing outstanding or is receiving its response (ready) in that same cycle.
  // A slave lane's valid is high for exactly the grant cycle; its ready closes ownership.

  // Master index 0 = instruction, 1 = data.
  logic [1:0]           m_valid, m_instr, m_ready;
  logic [1:0][AW-1:0]   m_addr;
  logic [1:0][DW-1:0]   m_wdata;
  logic [1:0][BW-1:0]   m_wstrb;

  logic [1:0]           pend_v, pend_instr, out_q, err_q;
  logic [1:0][AW-1:0]   pend_addr;
  logic [1:0][DW-1:0]   pend_wdata;
  logic [1:0][BW-1:0]   pend_wstrb;
  logic [1:0][SW-1:0]   pend_tgt;

  logic [1:0]           hit, accept, rsp_own, src_instr;
  logic [1:0][SW-1:0]   tgt;
  logic [1:0][DW-1:0]   rsp_data, src_wdata;
  logic [1:0][AW-1:0]   src_addr;
  logic [1:0][BW-1:0]   src_wstrb;
  logic [1:0][NSLV-1:0] req, gnt;

  state_t          state_q [NSLV];
  state_t          state_d [NSLV];
  logic [NSLV-1:0] rr_q, rr_d;

  assign m_valid = {dmemory_valid, imemory_valid};
  assign m_instr = {dmemory_instr, imemory_instr};
  assign m_addr  = {dmemory_addr, imemory_addr};
  assign m_wdata = {dmemory_wdata, imemory_wdata};
  assign m_wstrb = {dmemory_wstrb, imemory_wstrb};

  // Descending scan so the lowest matching slave index wins.
  always_comb begin
    for (int m = 0; m < 2; m++) begin
      hit[m] = 1'b0;
      tgt[m] = '0;
      for (int s = NSLV - 1; s >= 0; s--) begin
        if (m_addr[m] >= SLV_BASE[s*AW +: AW] && m_addr[m] < SLV_TOP[s*AW +: AW]) begin
          hit[m] = 1'b1;
          tgt[m] = SW'(s);
        end
      end
    end
  end

  always_comb begin
    rsp_own  = '0;
    rsp_data = '0;
    for (int s = 0; s < NSLV; s++) begin
      if (slv_ready[s] && state_q[s] == OWN_I) begin
        rsp_own[0]  = 1'b1;
        rsp_data[0] = rsp_data[0] | slv_rdata[s*DW +: DW];
      end
      if (slv_ready[s] && state_q[s] == OWN_D) begin
        rsp_own[1]  = 1'b1;
        rsp_data[1] = rsp_data[1] | slv_rdata[s*DW +: DW];
      end
    end
    req = '0;
    for (int m = 0; m < 2; m++) begin
      m_ready[m]   = !rst && (err_q[m] || rsp_own[m]);
      accept[m]    = m_valid[m] && !rst && (!out_q[m] || m_ready[m]);
      src_instr[m] = pend_v[m] ? pend_instr[m] : m_instr[m];
      src_addr[m]  = pend_v[m] ? pend_addr[m]  : m_addr[m];
      src_wdata[m] = pend_v[m] ? pend_wdata[m] : m_wdata[m];
      src_wstrb[m] = pend_v[m] ? pend_wstrb[m] : m_wstrb[m];
      for (int s = 0; s < NSLV; s++)
        req[m][s] = (pend_v[m] && pend_tgt[m] == SW'(s)) ||
                    (accept[m] && hit[m] && tgt[m] == SW'(s));
    end
  end

  always_comb begin
    rr_d = rr_q;
    gnt  = '0;
    for (int s = 0; s < NSLV; s++) begin
      state_d[s] = state_q[s];
      case (state_q[s])
        IDLE: begin
          if (req[0][s] && req[1][s]) begin
            gnt[rr_q[s]][s] = 1'b1;
            rr_d[s]         = ~rr_q[s];
          end else begin
            gnt[0][s] = req[0][s];
            gnt[1][s] = req[1][s];
          end
          if (gnt[0][s])      state_d[s] = OWN_I;
          else if (gnt[1][s]) state_d[s] = OWN_D;
        end
        default: if (slv_ready[s]) state_d[s] = IDLE;
      endcase
    end
  end

  always_comb begin
    slv_valid = '0;
    slv_instr = '0;
    slv_addr  = '0;
    slv_wdata = '0;
    slv_wstrb = '0;
    for (int s = 0; s < NSLV; s++) begin
      for (int m = 0; m < 2; m++) begin
        if (gnt[m][s]) begin
          slv_valid[s]          = 1'b1;
          slv_instr[s]          = src_instr[m];
          slv_addr[s*AW +: AW]  = src_addr[m] - SLV_BASE[s*AW +: AW];
          slv_wdata[s*DW +: DW] = src_wdata[m];
          slv_wstrb[s*BW +: BW] = src_wstrb[m];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= '0;
      for (int s = 0; s < NSLV; s++) state_q[s] <= IDLE;
    end else begin
      rr_q <= rr_d;
      for (int s = 0; s < NSLV; s++) state_q[s] <= state_d[s];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v     <= '0;
      pend_instr <= '0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      pend_wstrb <= '0;
      pend_tgt   <= '0;
      out_q      <= '0;
      err_q      <= '0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        err_q[m] <= accept[m] && !hit[m];
        if (accept[m])      out_q[m] <= 1'b1;
        else if (m_ready[m]) out_q[m] <= 1'b0;
        // A buffered request never coexists with a new accept: it keeps the master outstanding.
        if (accept[m] && hit[m] && !(|gnt[m])) begin
          pend_v[m]     <= 1'b1;
          pend_instr[m] <= m_instr[m];
          pend_addr[m]  <= m_addr[m];
          pend_wdata[m] <= m_wdata[m];
          pend_wstrb[m] <= m_wstrb[m];
          pend_tgt[m]   <= tgt[m];
        end else if (pend_v[m] && |gnt[m]) begin
          pend_v[m] <= 1'b0;
        end
      end
    end
  end

  assign imemory_ready = m_ready[0];
  assign dmemory_ready = m_ready[1];
  assign imemory_error = err_q[0];
  assign dmemory_error = err_q[1];
  assign imemory_rdata = err_q[0] ? ERR_RDATA : rsp_data[0];
  assign dmemory_rdata = err_q[1] ? ERR_RDATA : rsp_data[1];
endmodule

// File: tb/tb_mem_xbar.sv
// Bench for mem_xbar: decode vector table plus hand-written contention, round-robin,
// parallel, drop and mid-transaction reset sequences; responses checked via queues.
module tb_mem_xbar;
  localparam int NSLV = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam logic [NSLV*AW-1:0] BASE = {32'h8000_0000, 32'h1000_0000, 32'h0200_0000};
  localparam logic [NSLV*AW-1:0] TOP  = {32'h8001_0000, 32'h1000_1000, 32'h0201_0000};
  localparam logic [DW-1:0] ERR_RD = 32'hBAD0_BAD0;

  logic clk, rst;
  logic imemory_valid, imemory_instr, imemory_ready, imemory_error;
  logic [AW-1:0] imemory_addr;
  logic [DW-1:0] imemory_wdata, imemory_rdata;
  logic [BW-1:0] imemory_wstrb;
  logic dmemory_valid, dmemory_instr, dmemory_ready, dmemory_error;
  logic [AW-1:0] dmemory_addr;
  logic [DW-1:0] dmemory_wdata, dmemory_rdata;
  logic [BW-1:0] dmemory_wstrb;
  logic [NSLV-1:0] slv_valid, slv_instr, slv_ready;
  logic [NSLV*AW-1:0] slv_addr;
  logic [NSLV*DW-1:0] slv_wdata, slv_rdata;
  logic [NSLV*BW-1:0] slv_wstrb;

  int n_tests = 0;
  int n_fail = 0;
  logic [DW:0] exp_q_i[$];
  logic [DW:0] exp_q_d[$];

  mem_xbar #(.NSLV(NSLV), .AW(AW), .DW(DW), .SLV_BASE(BASE), .SLV_TOP(TOP),
             .ERR_RDATA(ERR_RD)) dut (
    .clk(clk), .rst(rst),
    .imemory_valid(imemory_valid), .imemory_instr(imemory_instr), .imemory_addr(imemory_addr),
    .imemory_wdata(imemory_wdata), .imemory_wstrb(imemory_wstrb), .imemory_rdata(imemory_rdata),
    .imemory_ready(imemory_ready), .imemory_error(imemory_error),
    .dmemory_valid(dmemory_valid), .dmemory_instr(dmemory_instr), .dmemory_addr(dmemory_addr),
    .dmemory_wdata(dmemory_wdata), .dmemory_wstrb(dmemory_wstrb), .dmemory_rdata(dmemory_rdata),
    .dmemory_ready(dmemory_ready), .dmemory_error(dmemory_error),
    .slv_valid(slv_valid), .slv_instr(slv_instr), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .slv_wstrb(slv_wstrb), .slv_rdata(slv_rdata), .slv_ready(slv_ready)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic clr();
    imemory_valid = 1'b0;
    dmemory_valid = 1'b0;
    slv_ready = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drv(input bit m, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input logic [BW-1:0] ws);
    if (!m) begin
      imemory_valid = 1'b1; imemory_instr = 1'b1; imemory_addr = a;
      imemory_wdata = wd; imemory_wstrb = ws;
    end else begin
      dmemory_valid = 1'b1; dmemory_instr = 1'b0; dmemory_addr = a;
      dmemory_wdata = wd; dmemory_wstrb = ws;
    end
  endtask

  task automatic push(input bit m, input logic [DW:0] v);
    if (!m) exp_q_i.push_back(v);
    else    exp_q_d.push_back(v);
  endtask

  task automatic rsp(input bit m, input int s, input logic [DW-1:0] rd, input bit expect_it);
    slv_ready[s] = 1'b1;
    slv_rdata[s*DW +: DW] = rd;
    if (expect_it) push(m, {1'b0, rd});
  endtask

  function automatic logic [63:0] all_out();
    return {52'd0, slv_valid, imemory_ready, dmemory_ready, imemory_error, dmemory_error,
            |slv_addr, |slv_wdata, |slv_wstrb, |slv_instr, |imemory_rdata, |dmemory_rdata};
  endfunction

  // Scoreboard
  logic [DW:0] got_i, got_d;
  always @(negedge clk) begin
    if (!rst) begin
      if (imemory_ready) begin
        if (exp_q_i.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL i_rsp: unexpected ready rdata %h at %0t", imemory_rdata, $time);
        end else begin
          got_i = exp_q_i.pop_front();
          chk("i_rsp", {31'd0, imemory_error, imemory_rdata}, {31'd0, got_i});
        end
      end
      if (dmemory_ready) begin
        if (exp_q_d.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL d_rsp: unexpected ready rdata %h at %0t", dmemory_rdata, $time);
        end else begin
          got_d = exp_q_d.pop_front();
          chk("d_rsp", {31'd0, dmemory_error, dmemory_rdata}, {31'd0, got_d});
        end
      end
    end
  end

  typedef struct {
    bit            m;
    logic [AW-1:0] addr;
    logic [BW-1:0] wstrb;
    int            slv;
    logic [AW-1:0] off;
  } vec_t;

  vec_t vec[9];
  logic [DW-1:0] wd, rd;
  logic [NSLV-1:0] ev;

  initial begin
    vec[0] = '{1'b1, 32'h8000_0010, 4'h0, 2, 32'h0000_0010};
    vec[1] = '{1'b0, 32'h8000_0000, 4'h0, 2, 32'h0000_0000};
    vec[2] = '{1'b0, 32'h8000_FFFC, 4'h0, 2, 32'h0000_FFFC};
    vec[3] = '{1'b1, 32'h8001_0000, 4'h0, -1, 32'h0};
    vec[4] = '{1'b1, 32'h1000_0004, 4'hF, 1, 32'h0000_0004};
    vec[5] = '{1'b0, 32'h0200_BFF8, 4'h3, 0, 32'h0000_BFF8};
    vec[6] = '{1'b1, 32'h01FF_FFFC, 4'h1, -1, 32'h0};
    vec[7] = '{1'b1, 32'hF000_0000, 4'h0, -1, 32'h0};
    vec[8] = '{1'b0, 32'h0000_0000, 4'h0, -1, 32'h0};

    rst = 1'b1;
    clr();
    imemory_instr = 0; imemory_addr = 0; imemory_wdata = 0; imemory_wstrb = 0;
    dmemory_instr = 0; dmemory_addr = 0; dmemory_wdata = 0; dmemory_wstrb = 0;
    slv_rdata = '0;

    // Reset: requests and slave readies during reset produce nothing.
    nxt();
    drv(0, 32'h8000_0000, 32'h1, 4'h0);
    drv(1, 32'h8000_0004, 32'h2, 4'hF);
    slv_ready = '1;
    slv_rdata = {NSLV{32'h1234_5678}};
    smp();
    chk("rst_outputs", all_out(), 64'd0);
    nxt();
    rst = 1'b0;
    smp();
    chk("post_rst_outputs", all_out(), 64'd0);

    // Decode table
    for (int k = 0; k < 9; k++) begin
      nxt();
      wd = $urandom;
      drv(vec[k].m, vec[k].addr, wd, vec[k].wstrb);
      if (vec[k].slv < 0) push(vec[k].m, {1'b1, ERR_RD});
      smp();
      ev = (vec[k].slv < 0) ? '0 : NSLV'(1 << vec[k].slv);
      chk("vec_valid", 64'(slv_valid), 64'(ev));
      if (vec[k].slv >= 0) begin
        chk("vec_addr",  64'(slv_addr[vec[k].slv*AW +: AW]),  64'(vec[k].off));
        chk("vec_wdata", 64'(slv_wdata[vec[k].slv*DW +: DW]), 64'(wd));
        chk("vec_wstrb", 64'(slv_wstrb[vec[k].slv*BW +: BW]), 64'(vec[k].wstrb));
        chk("vec_instr", 64'(slv_instr[vec[k].slv]),          64'(!vec[k].m));
      end
      nxt();
      if (vec[k].slv >= 0) begin
        rd = $urandom;
        rsp(vec[k].m, vec[k].slv, rd, 1'b1);
      end
      smp();
      chk("vec_no_reissue", 64'(slv_valid), 64'd0);
    end

    // Contention on slave 2, then repeat for round-robin (d wins second time).
    for (int r = 0; r < 2; r++) begin
      nxt();
      drv(0, 32'h8000_0100, 32'hAAAA_0000, 4'h0);
      drv(1, 32'h8000_0200, 32'hBBBB_0000, 4'hF);
      smp();
      chk("cont_valid", 64'(slv_valid), 64'h4);
      chk("cont_first_addr", 64'(slv_addr[2*AW +: AW]), (r == 0) ? 64'h100 : 64'h200);
      chk("cont_first_instr", 64'(slv_instr[2]), (r == 0) ? 64'd1 : 64'd0);
      nxt();
      smp();
      chk("cont_wait", 64'(slv_valid), 64'd0);
      nxt();
      rsp(r[0], 2, 32'hC0DE_0000 + 32'(r), 1'b1);
      smp();
      chk("cont_wait_rdy", 64'(slv_valid), 64'd0);
      nxt();
      smp();
      chk("cont_second_valid", 64'(slv_valid), 64'h4);
      chk("cont_second_addr", 64'(slv_addr[2*AW +: AW]), (r == 0) ? 64'h200 : 64'h100);
      chk("cont_second_wdata", 64'(slv_wdata[2*DW +: DW]), (r == 0) ? 64'hBBBB_0000 : 64'hAAAA_0000);
      nxt();
      rsp(!r[0], 2, 32'hFACE_0000 + 32'(r), 1'b1);
    end

    // Parallel i->slave 2, d->slave 1; d re-issues in its ready cycle (buffered, busy slave).
    nxt();
    drv(0, 32'h8000_0040, 32'h0, 4'h0);
    drv(1, 32'h1000_0004, 32'h0, 4'h0);
    smp();
    chk("par_valid", 64'(slv_valid), 64'h6);
    chk("par_addr_uart", 64'(slv_addr[1*AW +: AW]), 64'h4);
    chk("par_addr_bram", 64'(slv_addr[2*AW +: AW]), 64'h40);
    nxt();
    rsp(0, 2, 32'hDEAD_BEEF, 1'b1);
    rsp(1, 1, 32'h0000_0055, 1'b1);
    drv(1, 32'h1000_0008, 32'h77, 4'h1);
    smp();
    chk("par_rsp_valid", 64'(slv_valid), 64'd0);
    nxt();
    smp();
    chk("ready_cycle_issue", 64'(slv_valid), 64'h2);
    chk("ready_cycle_addr", 64'(slv_addr[1*AW +: AW]), 64'h8);
    nxt();
    rsp(1, 1, 32'h0000_0066, 1'b1);

    // Drop: a second d valid while outstanding is discarded.
    nxt();
    drv(1, 32'h0200_0000, 32'h0, 4'h0);
    smp();
    chk("drop_first", 64'(slv_valid), 64'h1);
    nxt();
    drv(1, 32'h0200_0004, 32'h0, 4'h0);
    smp();
    chk("drop_second", 64'(slv_valid), 64'd0);
    nxt();
    rsp(1, 0, 32'h0BAD_F00D, 1'b1);
    nxt();
    smp();
    chk("drop_no_issue", 64'(slv_valid), 64'd0);

    // Mid-op reset: slave 0 owned by d, i buffered behind it.
    nxt();
    drv(1, 32'h0200_0010, 32'h0, 4'h0);
    smp();
    chk("mid_grant_d", 64'(slv_valid), 64'h1);
    nxt();
    drv(0, 32'h0200_0020, 32'h0, 4'h0);
    smp();
    chk("mid_buffer_i", 64'(slv_valid), 64'd0);
    nxt();
    rst = 1'b1;
    slv_ready = '1;
    smp();
    chk("mid_rst_outputs", all_out(), 64'd0);
    nxt();
    rst = 1'b0;
    smp();
    chk("mid_after_rst", 64'(slv_valid), 64'd0);
    nxt();
    rsp(1, 0, 32'h5757_5757, 1'b0);
    smp();
    chk("mid_stale_ready", {62'd0, imemory_ready, dmemory_ready}, 64'd0);
    nxt();
    smp();
    chk("mid_no_issue", 64'(slv_valid), 64'd0);

    nxt();
    nxt();
    chk("q_i_drained", 64'(exp_q_i.size()), 64'd0);
    chk("q_d_drained", 64'(exp_q_d.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
